// File: rtl/piso_pkg.sv
// Shared types for the parallel-in serial-out serializer: FSM state encoding
// and bit-counter width helper.
package piso_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;

   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit counter: cleared on word load, counts 0..WIDTH-1 and saturates;
// tc flags the last data bit of the frame.
module piso_bit_counter #(
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tc
);
   import piso_pkg::*;

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable && !tc) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tc = (cnt == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready input and registered serial output.
// Optional even parity bit per frame when PISO_PARITY_EN is defined.
module piso_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             so,
   output logic             so_valid,
   output logic             sof,
   output logic             busy
);
   import piso_pkg::*;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg;
   logic             tc;
   logic             ready;
   logic             load;
   logic             step;
`ifdef PISO_PARITY_EN
   logic             par;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // The last frame cycle is also an acceptance slot, so frames can abut.
   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (din_valid) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (!tc) begin
               step = 1'b1;
            end else begin
`ifdef PISO_PARITY_EN
               state_nxt = PARITY;
`else
               ready = 1'b1;
               if (din_valid) begin
                  load = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
`endif
            end
         end
`ifdef PISO_PARITY_EN
         PARITY: begin
            ready = 1'b1;
            if (din_valid) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end else begin
               state_nxt = IDLE;
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shreg <= '0;
         so    <= 1'b0;
         sof   <= 1'b0;
`ifdef PISO_PARITY_EN
         par   <= 1'b0;
`endif
      end else if (load) begin
         so    <= MSB_FIRST ? din[WIDTH-1] : din[0];
         shreg <= MSB_FIRST ? (din << 1) : (din >> 1);
         sof   <= 1'b1;
`ifdef PISO_PARITY_EN
         par   <= ^din;
`endif
      end else if (step) begin
         so    <= MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
         shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
         sof   <= 1'b0;
`ifdef PISO_PARITY_EN
      end else if (state == SHIFT) begin
         so    <= par;
         sof   <= 1'b0;
`endif
      end else begin
         so    <= 1'b0;
         sof   <= 1'b0;
      end
   end

   piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (load),
      .enable (step),
      .tc     (tc)
   );

   assign din_ready = ready & rst_n;
   assign busy      = (state != IDLE);
   assign so_valid  = busy;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer (MSB-first and LSB-first instances).
module tb_piso_serializer;

   localparam int W = 8;
`ifdef PISO_PARITY_EN
   localparam int FL = W + 1;
`else
   localparam int FL = W;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] din, l_din;
   logic         din_valid, l_din_valid;
   logic         din_ready, l_din_ready;
   logic         so, l_so, so_valid, l_so_valid, sof, l_sof, busy, l_busy;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .so(so), .so_valid(so_valid), .sof(sof), .busy(busy)
   );

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .din(l_din), .din_valid(l_din_valid), .din_ready(l_din_ready),
      .so(l_so), .so_valid(l_so_valid), .sof(l_sof), .busy(l_busy)
   );

   // Expected bit at frame position pos (0-based); position W is the even-parity bit.
   function automatic logic exp_bit(input logic [W-1:0] w, input int pos, input logic msb);
      if (pos >= W) return ^w;
      return msb ? w[W-1-pos] : w[pos];
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; din = '0; din_valid = 1'b0; l_din = '0; l_din_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (din_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b exp 0", din_ready); end
      checks++; if (so !== 1'b0) begin fails++; $display("FAIL rst_so: got %b exp 0", so); end
      checks++; if (so_valid !== 1'b0) begin fails++; $display("FAIL rst_so_valid: got %b exp 0", so_valid); end
      checks++; if (sof !== 1'b0) begin fails++; $display("FAIL rst_sof: got %b exp 0", sof); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b exp 0", busy); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (din_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready: got %b exp 1", din_ready); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_release_busy: got %b exp 0", busy); end
   endtask

   task automatic test_msb_frame(input logic [W-1:0] w);
      checks++; if (din_ready !== 1'b1) begin fails++; $display("FAIL msb_ready_c0: got %b exp 1", din_ready); end
      din = w; din_valid = 1'b1;
      for (int k = 1; k <= FL; k++) begin
         @(negedge clk);
         if (k == 1) din_valid = 1'b0;
         checks++; if (so !== exp_bit(w, k-1, 1'b1)) begin fails++; $display("FAIL msb_so w=%h c=%0d: got %b exp %b", w, k, so, exp_bit(w, k-1, 1'b1)); end
         checks++; if (so_valid !== 1'b1) begin fails++; $display("FAIL msb_so_valid c=%0d: got %b exp 1", k, so_valid); end
         checks++; if (sof !== (k == 1)) begin fails++; $display("FAIL msb_sof c=%0d: got %b exp %b", k, sof, (k == 1)); end
         checks++; if (din_ready !== (k == FL)) begin fails++; $display("FAIL msb_ready c=%0d: got %b exp %b", k, din_ready, (k == FL)); end
      end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL msb_busy_end: got %b exp 0", busy); end
      checks++; if (so_valid !== 1'b0 || so !== 1'b0) begin fails++; $display("FAIL msb_idle_out: got so_valid=%b so=%b exp 0 0", so_valid, so); end
   endtask

   // Two words offered continuously; the second is held while the first shifts.
   task automatic test_back_to_back(input logic [W-1:0] w1, input logic [W-1:0] w2);
      logic [W-1:0] w;
      int           pos;
      din = w1; din_valid = 1'b1;
      for (int c = 1; c <= 2*FL; c++) begin
         @(negedge clk);
         w   = (c <= FL) ? w1 : w2;
         pos = (c <= FL) ? c - 1 : c - 1 - FL;
         checks++; if (so_valid !== 1'b1) begin fails++; $display("FAIL b2b_so_valid w=%h c=%0d: got %b exp 1", w2, c, so_valid); end
         checks++; if (so !== exp_bit(w, pos, 1'b1)) begin fails++; $display("FAIL b2b_so w=%h c=%0d: got %b exp %b", w, c, so, exp_bit(w, pos, 1'b1)); end
         checks++; if (sof !== (c == 1 || c == FL+1)) begin fails++; $display("FAIL b2b_sof c=%0d: got %b exp %b", c, sof, (c == 1 || c == FL+1)); end
         if (c < 2*FL) begin
            checks++; if (din_ready !== (c == FL)) begin fails++; $display("FAIL b2b_ready c=%0d: got %b exp %b", c, din_ready, (c == FL)); end
         end
         if (c == 1) din = w2;
         if (c == FL+1) din_valid = 1'b0;
      end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_busy_end: got %b exp 0", busy); end
   endtask

   task automatic test_lsb_first();
      l_din = 8'h01; l_din_valid = 1'b1;
      for (int k = 1; k <= FL; k++) begin
         @(negedge clk);
         if (k == 1) l_din_valid = 1'b0;
         checks++; if (l_so !== exp_bit(8'h01, k-1, 1'b0)) begin fails++; $display("FAIL lsb_so c=%0d: got %b exp %b", k, l_so, exp_bit(8'h01, k-1, 1'b0)); end
         checks++; if (l_sof !== (k == 1)) begin fails++; $display("FAIL lsb_sof c=%0d: got %b exp %b", k, l_sof, (k == 1)); end
         checks++; if (l_so_valid !== 1'b1) begin fails++; $display("FAIL lsb_so_valid c=%0d: got %b exp 1", k, l_so_valid); end
      end
      @(negedge clk);
      checks++; if (l_busy !== 1'b0) begin fails++; $display("FAIL lsb_busy_end: got %b exp 0", l_busy); end
   endtask

   task automatic test_reset_mid_frame();
      din = 8'hFF; din_valid = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) din_valid = 1'b0;
         checks++; if (so !== 1'b1) begin fails++; $display("FAIL rmid_so c=%0d: got %b exp 1", k, so); end
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (so !== 1'b0 || so_valid !== 1'b0) begin fails++; $display("FAIL rmid_abort: got so=%b so_valid=%b exp 0 0", so, so_valid); end
      checks++; if (din_ready !== 1'b0) begin fails++; $display("FAIL rmid_ready_in_reset: got %b exp 0", din_ready); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (din_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready_release: got %b exp 1", din_ready); end
      checks++; if (so_valid !== 1'b0) begin fails++; $display("FAIL rmid_no_residue: got %b exp 0", so_valid); end
      din = 8'h96; din_valid = 1'b1;
      for (int k = 1; k <= FL; k++) begin
         @(negedge clk);
         if (k == 1) din_valid = 1'b0;
         checks++; if (so !== exp_bit(8'h96, k-1, 1'b1)) begin fails++; $display("FAIL rmid_next_so c=%0d: got %b exp %b", k, so, exp_bit(8'h96, k-1, 1'b1)); end
         checks++; if (sof !== (k == 1)) begin fails++; $display("FAIL rmid_next_sof c=%0d: got %b exp %b", k, sof, (k == 1)); end
      end
      @(negedge clk);
   endtask

`ifdef PISO_PARITY_EN
   task automatic test_parity(input logic [W-1:0] w, input logic p);
      din = w; din_valid = 1'b1;
      repeat (FL) begin
         @(negedge clk);
         din_valid = 1'b0;
      end
      checks++; if (so !== p) begin fails++; $display("FAIL parity_bit w=%h: got %b exp %b", w, so, p); end
      checks++; if (din_ready !== 1'b1) begin fails++; $display("FAIL parity_ready w=%h: got %b exp 1", w, din_ready); end
      checks++; if (so_valid !== 1'b1) begin fails++; $display("FAIL parity_so_valid w=%h: got %b exp 1", w, so_valid); end
      @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_msb_frame(8'hA5);
      test_msb_frame(8'h3C);
      test_back_to_back(8'hA5, 8'h3C);
      test_back_to_back(8'h81, 8'h5A);
      test_lsb_first();
      test_reset_mid_frame();
`ifdef PISO_PARITY_EN
      test_parity(8'hA5, 1'b0);
      test_parity(8'h07, 1'b1);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL provide parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 shifted first, 0 = bit 0 first.
REQ-003 The block SHALL provide port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 The block SHALL provide port rst_n, input, 1, synchronous active-low reset.
REQ-005 The block SHALL provide port din, input, WIDTH, parallel word to serialize.
REQ-006 The block SHALL provide port din_valid, input, 1, din holds a valid word.
REQ-007 The block SHALL provide port din_ready, output, 1, block accepts din this cycle.
REQ-008 The block SHALL provide port so, output, 1, serial data bit, registered, drives downstream shift chain input si.
REQ-009 The block SHALL provide port so_valid, output, 1, so carries a frame bit this cycle.
REQ-010 The block SHALL provide port sof, output, 1, high with the first bit of each frame.
REQ-011 The block SHALL provide port busy, output, 1, a frame is in progress.

Function
REQ-012 Word acceptance SHALL occur only on a cycle where din_valid && din_ready.
REQ-013 FSM states SHALL be IDLE and SHIFT, plus PARITY when PISO_PARITY_EN is defined.
REQ-014 IDLE: din_ready=1; on acceptance, load shift register with din, clear bit counter, go to SHIFT.
REQ-015 The first frame bit SHALL appear on so with so_valid=1, sof=1 on the cycle after acceptance (latency 1).
REQ-016 SHIFT: one bit per cycle; the counter increments from 0 to WIDTH-1; the order follows MSB_FIRST.
REQ-017 din_ready SHALL be 0 in SHIFT except on the last frame cycle (counter=WIDTH-1 with parity disabled, or in the PARITY state with parity enabled).
REQ-018 Acceptance on the last frame cycle SHALL reload and start the next frame with no idle gap; otherwise the FSM returns to IDLE.
REQ-019 While din_valid=1 and din_ready=0, din SHALL be ignored and not lost; the source holds it per the valid/ready rule.
REQ-020 In IDLE, so=0, so_valid=0, sof=0 and busy=0; busy=1 in every non-IDLE state.
REQ-021 Deassertion of din_valid mid-frame SHALL have no effect on the frame in progress.
REQ-022 The bit counter SHALL be $clog2(WIDTH) bits wide and never exceed WIDTH-1.

Reset
REQ-023 With rst_n=0 at a clk edge: state=IDLE, counter=0, shift register=0, so=0, so_valid=0, sof=0, busy=0.
REQ-024 din_ready SHALL be 0 while rst_n=0 and 1 on the first cycle after release.
REQ-025 Reset mid-frame SHALL abort the frame; the remaining bits are discarded and never emitted.

Configuration
REQ-026 Macro PISO_PARITY_EN defined: after the last data bit, one PARITY cycle drives so = XOR of all WIDTH data bits (even parity) with so_valid=1; frame length is WIDTH+1.
REQ-027 Macro PISO_PARITY_EN undefined: no PARITY state or logic is present; frame length is exactly WIDTH.

Structure
REQ-028 Package piso_pkg SHALL hold the FSM state typedef (IDLE, SHIFT, PARITY) and the counter-width constant function.
REQ-029 Sub-module piso_bit_counter (clear, enable, terminal-count output) SHALL be instantiated once; all other logic stays in piso_serializer.

Verification
REQ-030 WIDTH=8, MSB_FIRST=1, din=8'hA5 accepted at cycle 0 -> so=1,0,1,0,0,1,0,1 in cycles 1..8; sof=1 at cycle 1 only; busy=0 at cycle 9.
REQ-031 8'hA5 then 8'h3C offered back-to-back -> 16 contiguous so_valid cycles; the second sof is at cycle 9; din_ready=1 only in cycles 0 and 8.
REQ-032 MSB_FIRST=0, din=8'h01 -> so=1 at cycle 1, then 0 in cycles 2..8.
REQ-033 rst_n=0 at cycle 4 of an 8'hFF frame -> so=0, so_valid=0 from cycle 5; din_ready=1 after release; the next word serializes from its first bit.
REQ-034 PISO_PARITY_EN defined, din=8'hA5 -> 8 data bits then parity bit 0 at cycle 9; din=8'h07 -> parity bit 1; din_ready=1 on the parity cycle.
REQ-035 din_valid held high with 8'h5A while busy -> no acceptance until the last frame cycle; 8'h5A then serializes intact.
